// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
//
// Bridges the last-level cache and the burst memory interface. A 256-bit
// cacheline read or write from the cache becomes one BEATS x BEAT_W burst on
// bmem. Read beats are assembled into line_rdata. Completion of either kind is
// reported to the cache with a single-cycle line_resp pulse. Only one request
// is in flight at a time.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   line_addr    cache request byte address (sampled in IDLE only)
//   line_read    line read request, held by the cache until line_resp
//   line_write   line write request, held by the cache until line_resp
//   line_wdata   line to write, beat 0 = bits [BEAT_W-1:0]
//   line_rdata   assembled read line, valid from the line_resp cycle
//   line_resp    one-cycle completion pulse
//   bmem_addr    line-aligned burst address, 0 when no burst is active
//   bmem_read    burst read request
//   bmem_write   burst write request
//   bmem_wdata   current write beat
//   bmem_rdata   read beat, valid when bmem_resp=1
//   bmem_resp    per-beat acknowledge; gaps of any length are legal
// -----------------------------------------------------------------------------
module cacheline_adapter #(
    parameter  int BEAT_W = 64,
    parameter  int BEATS  = 4,
    localparam int LINE_W = BEAT_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       line_addr,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,

    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    // Byte-offset bits inside one line; these are cleared on bmem_addr.
    localparam int OFS_W = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(BEATS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [31-OFS_W:0] addr_q;    // only the line-aligned part is ever used
    logic [LINE_W-1:0] wdata_q;

    logic              burst_active;
    logic              last_beat;

    // The offset bits of the request address are intentionally dropped; this
    // reduction only marks them as consumed.
    logic              unused_ofs;
    assign unused_ofs = ^line_addr[OFS_W-1:0];

    assign burst_active = (state == RD) || (state == WR);
    assign last_beat    = (cnt == LAST_BEAT);

    // -------------------------------------------------------------------------
    // State, beat counter and captured request
    // -------------------------------------------------------------------------
    // NOTE: every register here, including the wide data registers, is cleared
    // by reset so that all outputs read as zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge value of cnt and state.
            case (state)
                IDLE: begin
                    // Write wins when both requests are raised together.
                    if (line_write) begin
                        addr_q  <= line_addr[31:OFS_W];
                        wdata_q <= line_wdata;
                        state   <= WR;
                    end else if (line_read) begin
                        addr_q  <= line_addr[31:OFS_W];
                        state   <= RD;
                    end
                end

                RD: begin
                    if (bmem_resp) begin
                        line_rdata[cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end

                WR: begin
                    if (bmem_resp) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    // bmem_resp is ignored here; the pulse lasts one cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from state so that they drop the instant rst rises
    // -------------------------------------------------------------------------
    // NOTE: each output gets a value on every path, so no latch is inferred.
    always_comb begin
        bmem_read  = (state == RD);
        bmem_write = (state == WR);
        line_resp  = (state == DONE);
        bmem_addr  = burst_active ? {addr_q, {OFS_W{1'b0}}} : 32'd0;
        // The beat follows cnt directly, so it only steps on an acknowledge.
        bmem_wdata = (state == WR) ? wdata_q[cnt*BEAT_W +: BEAT_W] : '0;
    end

endmodule
